// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST result checker.
//   - DATA_in word layout: {addr, expected, actual}, field offsets below.
//   - Checker FSM state type.
package mbist_pkg;

    localparam int unsigned WORD_W   = 52;
    localparam int unsigned ADDR_LSB = 48;
    localparam int unsigned EXP_LSB  = 24;
    localparam int unsigned ACT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mbist_fail_log.sv
// Synchronous first-word-fall-through FIFO that holds MBIST fail records.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   clear         synchronous flush; it takes priority over push and pop
//   push, din     enqueue; dropped when full unless a pop happens in the same cycle
//   pop           dequeue head; ignored while empty
//   dout          head entry, reads 0 while empty
//   full, empty   occupancy flags
module mbist_fail_log #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full log frees the slot the simultaneous push needs.
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !clear && !empty;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mbist_result_checker.sv
// Checks the MBIST engine's DATA_in stream, counts and logs mismatches,
// and latches a pass/fail verdict once the engine reports completion.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   MBIST_start              starts (or restarts) a run and clears all results
//   DATA_in, data_valid      {addr, expected, actual} word and its qualifier
//   MBIST_done               engine completion pulse
//   check_done, check_pass   verdict valid / zero mismatches in the last run
//   fail_count               saturating mismatch count
//   log_valid, log_addr,
//   log_syndrome, log_pop    fail-log head (expected^actual) and dequeue
//   log_overflow             sticky: a mismatch was dropped because the log was full
module mbist_result_checker
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned LOG_DEPTH = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MBIST_start,
    input  logic [51:0]       DATA_in,
    input  logic              data_valid,
    input  logic              MBIST_done,
    output logic              check_done,
    output logic              check_pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_syndrome,
    input  logic              log_pop,
    output logic              log_overflow
);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0]        word_addr;
    logic [DATA_W-1:0]        word_exp;
    logic [DATA_W-1:0]        word_act;
    logic                     word_check;
    logic                     mismatch;
    logic                     log_full;
    logic                     log_empty;
    logic [ADDR_W+DATA_W-1:0] log_head;

    assign word_addr = DATA_in[ADDR_LSB +: ADDR_W];
    assign word_exp  = DATA_in[EXP_LSB  +: DATA_W];
    assign word_act  = DATA_in[ACT_LSB  +: DATA_W];

    // A word arriving with the start pulse belongs to no run and is ignored.
    assign word_check = (state == RUN) && data_valid && !MBIST_start;
    assign mismatch   = word_check && (word_exp != word_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (MBIST_start) next_state = RUN;
            RUN:     if (MBIST_start) next_state = RUN;
                     else if (MBIST_done) next_state = DONE;
            DONE:    if (MBIST_start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_count   <= '0;
            log_overflow <= 1'b0;
            check_done   <= 1'b0;
            check_pass   <= 1'b0;
        end else if (MBIST_start) begin
            fail_count   <= '0;
            log_overflow <= 1'b0;
            check_done   <= 1'b0;
            check_pass   <= 1'b0;
        end else begin
            if (mismatch && (fail_count != '1))
                fail_count <= fail_count + CNT_W'(1);
            if (mismatch && log_full && !log_pop)
                log_overflow <= 1'b1;
            // The verdict must include a mismatch on the word coincident with done.
            if ((state == RUN) && MBIST_done) begin
                check_done <= 1'b1;
                check_pass <= (fail_count == '0) && !mismatch;
            end
        end
    end

    mbist_fail_log #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (LOG_DEPTH)
    ) u_fail_log (
        .clk   (clk),
        .rst   (rst),
        .clear (MBIST_start),
        .push  (mismatch),
        .pop   (log_pop),
        .din   ({word_addr, word_exp ^ word_act}),
        .dout  (log_head),
        .full  (log_full),
        .empty (log_empty)
    );

    assign log_valid    = !log_empty;
    assign log_addr     = log_head[DATA_W +: ADDR_W];
    assign log_syndrome = log_head[DATA_W-1:0];

endmodule

// File: tb/tb_mbist_result_checker.sv
module tb_mbist_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MBIST_start = 1'b0;
    logic [51:0] DATA_in = '0;
    logic        data_valid = 1'b0;
    logic        MBIST_done = 1'b0;
    logic        log_pop = 1'b0;
    logic        check_done;
    logic        check_pass;
    logic [7:0]  fail_count;
    logic        log_valid;
    logic [3:0]  log_addr;
    logic [23:0] log_syndrome;
    logic        log_overflow;

    int total = 0;
    int bad   = 0;

    mbist_result_checker #(
        .ADDR_W    (4),
        .DATA_W    (24),
        .LOG_DEPTH (8),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MBIST_start  (MBIST_start),
        .DATA_in      (DATA_in),
        .data_valid   (data_valid),
        .MBIST_done   (MBIST_done),
        .check_done   (check_done),
        .check_pass   (check_pass),
        .fail_count   (fail_count),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_syndrome (log_syndrome),
        .log_pop      (log_pop),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: results of the run as plain integers and a queue.
    typedef struct {
        logic [3:0]  a;
        logic [23:0] s;
    } ent_t;

    ent_t m_q[$];
    int   m_cnt;
    bit   m_running;
    bit   m_ovf;
    bit   m_done;
    bit   m_pass;

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_running = 0; m_ovf = 0; m_done = 0; m_pass = 0;
    endtask

    task automatic model_clock(bit st, bit dv, logic [3:0] a, logic [23:0] e,
                               logic [23:0] ac, bit dn, bit pp);
        bit mism;
        if (st) begin
            model_reset();
            m_running = 1;
            return;
        end
        if (pp && m_q.size() > 0) void'(m_q.pop_front());
        mism = m_running && dv && (e != ac);
        if (mism) begin
            if (m_cnt < 255) m_cnt++;
            if (m_q.size() < 8) m_q.push_back('{a: a, s: e ^ ac});
            else m_ovf = 1;
        end
        if (m_running && dn) begin
            m_done = 1;
            m_pass = (m_cnt == 0);
            m_running = 0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".check_done"},   32'(check_done),   32'(m_done));
        chk({tag, ".check_pass"},   32'(check_pass),   32'(m_pass));
        chk({tag, ".fail_count"},   32'(fail_count),   32'(m_cnt));
        chk({tag, ".log_valid"},    32'(log_valid),    32'(m_q.size() > 0));
        chk({tag, ".log_addr"},     32'(log_addr),     m_q.size() > 0 ? 32'(m_q[0].a) : 32'd0);
        chk({tag, ".log_syndrome"}, 32'(log_syndrome), m_q.size() > 0 ? 32'(m_q[0].s) : 32'd0);
        chk({tag, ".log_overflow"}, 32'(log_overflow), 32'(m_ovf));
    endtask

    task automatic step(string tag, bit st, bit dv, logic [3:0] a, logic [23:0] e,
                        logic [23:0] ac, bit dn, bit pp);
        @(negedge clk);
        MBIST_start = st;
        data_valid  = dv;
        DATA_in     = {a, e, ac};
        MBIST_done  = dn;
        log_pop     = pp;
        @(posedge clk);
        model_clock(st, dv, a, e, ac, dn, pp);
        #1;
        check_all(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 0, 0, 4'd0, 24'd0, 24'd0, 0, 0);
    endtask

    task automatic start(string tag);
        step(tag, 1, 0, 4'd0, 24'd0, 24'd0, 0, 0);
    endtask

    task automatic word(string tag, logic [3:0] a, bit mism, bit dn, bit pp);
        logic [23:0] e;
        logic [23:0] ac;
        e  = 24'($urandom);
        ac = mism ? (e ^ (24'd1 << $urandom_range(23, 0))) : e;
        step(tag, 0, 1, a, e, ac, dn, pp);
    endtask

    task automatic pop(string tag);
        step(tag, 0, 0, 4'd0, 24'd0, 24'd0, 0, 1);
    endtask

    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Power-on reset.
        async_reset("por");

        // Reset mid-run after three mismatches, then an empty run passes.
        start("r_start");
        for (int i = 0; i < 3; i++) word("r_word", 4'(i), 1, 0, 0);
        async_reset("r_mid");
        start("r_start2");
        step("r_done", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);
        chk("empty_run_pass", 32'(check_pass), 32'd1);

        // Sixteen matching words.
        start("m_start");
        for (int i = 0; i < 16; i++) word("m_word", 4'(i), 0, 0, 0);
        idle("m_pre");
        chk("m_no_verdict", 32'(check_done), 32'd0);
        step("m_done", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);
        chk("m_pass", 32'(check_pass), 32'd1);
        idle("m_hold");

        // Two directed mismatches.
        start("d_start");
        for (int i = 0; i < 16; i++) begin
            if (i == 3)      step("d_w3", 0, 1, 4'd3, 24'hAAAAAA, 24'hAAAAAB, 0, 0);
            else if (i == 9) step("d_w9", 0, 1, 4'd9, 24'h555555, 24'h545555, 0, 0);
            else             word("d_word", 4'(i), 0, 0, 0);
        end
        step("d_done", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);
        chk("d_count", 32'(fail_count), 32'd2);
        chk("d_pass", 32'(check_pass), 32'd0);
        chk("d_head0_addr", 32'(log_addr), 32'd3);
        chk("d_head0_syn", 32'(log_syndrome), 32'h000001);
        pop("d_pop0");
        chk("d_head1_addr", 32'(log_addr), 32'd9);
        chk("d_head1_syn", 32'(log_syndrome), 32'h010000);
        pop("d_pop1");
        chk("d_empty", 32'(log_valid), 32'd0);
        pop("d_pop_empty");

        // Ten mismatches into an eight-entry log.
        start("o_start");
        for (int i = 0; i < 10; i++) word("o_word", 4'(i), 1, 0, 0);
        chk("o_count", 32'(fail_count), 32'd10);
        chk("o_ovf", 32'(log_overflow), 32'd1);
        step("o_done", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            chk("o_pop_addr", 32'(log_addr), 32'(i));
            pop("o_pop");
        end
        chk("o_drained", 32'(log_valid), 32'd0);

        // Full log with simultaneous push and pop, then counter saturation.
        start("s_start");
        for (int i = 0; i < 8; i++) word("s_fill", 4'(i), 1, 0, 0);
        word("s_pushpop", 4'd8, 1, 0, 1);
        chk("s_no_ovf", 32'(log_overflow), 32'd0);
        chk("s_head_after", 32'(log_addr), 32'd1);
        for (int i = 0; i < 300; i++) word("s_sat", 4'(i), 1, 0, 0);
        chk("s_saturated", 32'(fail_count), 32'd255);
        step("s_done", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);
        for (int i = 0; i < 9; i++) pop("s_drain");

        // Mismatch coincident with done; data_valid in DONE; mid-run restart.
        start("c_start");
        word("c_ok", 4'd1, 0, 0, 0);
        word("c_last", 4'd2, 1, 1, 0);
        chk("c_count", 32'(fail_count), 32'd1);
        chk("c_pass", 32'(check_pass), 32'd0);
        word("c_in_done", 4'd5, 1, 0, 0);
        chk("c_done_ignored", 32'(fail_count), 32'd1);
        start("c_restart0");
        word("c_mm", 4'd4, 1, 0, 0);
        word("c_mm", 4'd6, 1, 0, 0);
        step("c_restart", 1, 1, 4'd7, 24'h123456, 24'h654321, 0, 0);
        chk("c_cleared", 32'(fail_count), 32'd0);
        chk("c_log_cleared", 32'(log_valid), 32'd0);
        step("c_done2", 0, 0, 4'd0, 24'd0, 24'd0, 1, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit st;
            bit dn;
            bit dv;
            bit pp;
            logic [23:0] e;
            logic [23:0] ac;
            st = ($urandom_range(99, 0) < 4);
            dn = ($urandom_range(99, 0) < 5);
            dv = ($urandom_range(99, 0) < 60);
            pp = ($urandom_range(99, 0) < 25);
            e  = 24'($urandom);
            ac = ($urandom_range(1, 0) == 1) ? 24'($urandom) : e;
            step("rnd", st, dv, 4'($urandom), e, ac, dn, pp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
